// File: rtl/expand_key_seq_pkg.sv
// Shared AES definitions: word/key typedefs, S-box table and the key-schedule helper functions.
// The FSM state set depends on EXPAND_KEY_INV_MIX_EN (adds INVMIX when defined).
package AESDefinitions;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] roundKey_t;
  typedef logic [255:0] key_t;

`ifdef EXPAND_KEY_INV_MIX_EN
  typedef enum logic [1:0] {IDLE, EXPAND, INVMIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
`endif

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic word_t SubWord(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic word_t RotWord(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant, enough for the 09/0b/0d/0e inverse coefficients
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8, r;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    r = 8'h00;
    if (c[0]) r ^= b;
    if (c[1]) r ^= x2;
    if (c[2]) r ^= x4;
    if (c[3]) r ^= x8;
    return r;
  endfunction

  function automatic roundKey_t InvMixColumns(input roundKey_t s);
    roundKey_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/expand_key_seq_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, shared by both schedule substitution cases.
module sub_word
  import AESDefinitions::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end

endmodule

// File: rtl/expand_key_seq.sv
// Sequential AES-128/192/256 key expansion, one schedule word per clock, with indexed round-key reads.
// Define EXPAND_KEY_INV_MIX_EN to also build the equivalent-inverse-cipher keys (inv_round_key port).
module expand_key_seq
  import AESDefinitions::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic [3:0]          rk_index,
  output logic [127:0]        round_key,
  output logic                keys_valid
`ifdef EXPAND_KEY_INV_MIX_EN
  ,
  output logic [127:0]        inv_round_key
`endif
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $fatal(1, "expand_key_seq: KEY_BITS must be 128, 192 or 256");
  end

  state_t     state, next_state;
  logic [5:0] cnt;
  logic [2:0] phase;
  logic [7:0] rcon;
  word_t      w [NW];
  word_t      prev_word, far_word, sw_in, sw_out, temp, new_word;
  logic       at_rcon, at_sub4, last_word, handshake;
  logic [5:0] base;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    key_ready  = 1'b0;
    keys_valid = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) next_state = EXPAND;
      end
      EXPAND: begin
        if (last_word) begin
`ifdef EXPAND_KEY_INV_MIX_EN
          next_state = INVMIX;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef EXPAND_KEY_INV_MIX_EN
      INVMIX: begin
        if (cnt == 6'(NR - 1)) next_state = DONE;
      end
`endif
      DONE: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
        if (key_valid) next_state = EXPAND;
      end
      default: next_state = IDLE;
    endcase
  end

  assign handshake = key_valid && key_ready;

  // phase tracks i mod Nk alongside the word counter, avoiding a divider
  assign prev_word = w[cnt - 6'd1];
  assign far_word  = w[cnt - 6'(NK)];
  assign at_rcon   = (phase == 3'd0);
  assign at_sub4   = (NK == 8) && (phase == 3'd4);
  assign last_word = (cnt == 6'(NW - 1));
  assign sw_in     = at_rcon ? RotWord(prev_word) : prev_word;

  sub_word u_sub_word (
    .din  (sw_in),
    .dout (sw_out)
  );

  always_comb begin
    temp = prev_word;
    if (at_rcon)      temp = sw_out ^ {rcon, 24'h000000};
    else if (at_sub4) temp = sw_out;
  end

  assign new_word = far_word ^ temp;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      phase <= '0;
      rcon  <= '0;
    end else if (handshake) begin
      cnt   <= 6'(NK);
      phase <= '0;
      rcon  <= 8'h01;
    end else if (state == EXPAND) begin
      cnt   <= last_word ? 6'd1 : cnt + 6'd1;
      phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
      if (at_rcon) rcon <= xtime(rcon);
    end
`ifdef EXPAND_KEY_INV_MIX_EN
    else if (state == INVMIX) begin
      cnt <= cnt + 6'd1;
    end
`endif
  end

  // The word store is never cleared; its contents only matter once keys_valid is high
  always_ff @(posedge clock) begin
    if (handshake) begin
      for (int k = 0; k < NK; k++) w[k] <= key[KEY_BITS-1-32*k -: 32];
    end else if (state == EXPAND) begin
      w[cnt] <= new_word;
    end
  end

  assign base = {rk_index, 2'b00};

  always_comb begin
    round_key = '0;
    if (rk_index <= 4'(NR))
      round_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

`ifdef EXPAND_KEY_INV_MIX_EN
  roundKey_t  inv_store [NR+1];
  roundKey_t  rk_cur;
  logic [5:0] inv_base;

  assign inv_base = {cnt[3:0], 2'b00};
  assign rk_cur   = {w[inv_base], w[inv_base + 6'd1], w[inv_base + 6'd2], w[inv_base + 6'd3]};

  // First and last round keys pass through unmixed, copied during the first INVMIX step
  always_ff @(posedge clock) begin
    if (state == INVMIX) begin
      inv_store[cnt[3:0]] <= InvMixColumns(rk_cur);
      if (cnt == 6'd1) begin
        inv_store[0]  <= {w[0], w[1], w[2], w[3]};
        inv_store[NR] <= {w[NW-4], w[NW-3], w[NW-2], w[NW-1]};
      end
    end
  end

  always_comb begin
    inv_round_key = '0;
    if (rk_index <= 4'(NR)) inv_round_key = inv_store[rk_index];
  end
`endif

endmodule

// File: tb/tb_expand_key_seq.sv
// Scoreboard bench for expand_key_seq: one instance per key size, FIPS-197 reference schedules.
// Inverse-key expectations are added when EXPAND_KEY_INV_MIX_EN is defined.
module tb_expand_key_seq;

  typedef struct {
    string        tag;
    logic [3:0]   idx;
    logic         inv;
    logic [127:0] exp;
  } exp_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clock = 1'b0;
  logic         reset;
  logic         key_valid_all;
  logic [255:0] key_bus;
  logic [3:0]   rk_index;
  int           sel;

  logic         ready128, ready192, ready256;
  logic         valid128, valid192, valid256;
  logic [127:0] rk128, rk192, rk256;
  logic [127:0] inv128, inv192, inv256;
  logic         obs_ready, obs_valid;
  logic [127:0] obs_rk, obs_inv;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  expand_key_seq #(.KEY_BITS(128)) dut128 (
    .clock(clock), .reset(reset), .key_valid(key_valid_all && sel == 128), .key_ready(ready128),
    .key(key_bus[255 -: 128]), .rk_index(rk_index), .round_key(rk128), .keys_valid(valid128)
`ifdef EXPAND_KEY_INV_MIX_EN
    , .inv_round_key(inv128)
`endif
  );

  expand_key_seq #(.KEY_BITS(192)) dut192 (
    .clock(clock), .reset(reset), .key_valid(key_valid_all && sel == 192), .key_ready(ready192),
    .key(key_bus[255 -: 192]), .rk_index(rk_index), .round_key(rk192), .keys_valid(valid192)
`ifdef EXPAND_KEY_INV_MIX_EN
    , .inv_round_key(inv192)
`endif
  );

  expand_key_seq #(.KEY_BITS(256)) dut256 (
    .clock(clock), .reset(reset), .key_valid(key_valid_all && sel == 256), .key_ready(ready256),
    .key(key_bus), .rk_index(rk_index), .round_key(rk256), .keys_valid(valid256)
`ifdef EXPAND_KEY_INV_MIX_EN
    , .inv_round_key(inv256)
`endif
  );

`ifndef EXPAND_KEY_INV_MIX_EN
  assign inv128 = '0;
  assign inv192 = '0;
  assign inv256 = '0;
`endif

  always_comb begin
    obs_ready = ready128;
    obs_valid = valid128;
    obs_rk    = rk128;
    obs_inv   = inv128;
    if (sel == 192) begin
      obs_ready = ready192;
      obs_valid = valid192;
      obs_rk    = rk192;
      obs_inv   = inv192;
    end else if (sel == 256) begin
      obs_ready = ready256;
      obs_valid = valid256;
      obs_rk    = rk256;
      obs_inv   = inv256;
    end
  end

  // Independent GF(2^8) reference used for the inverse-key expectations
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] o;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gf_mul(s[127-32*c-8*k -: 8], m[(k - r + 4) % 4]);
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic int expected_latency(input int bits);
`ifdef EXPAND_KEY_INV_MIX_EN
    return (bits == 128) ? 49 : (bits == 192) ? 57 : 65;
`else
    return (bits == 128) ? 40 : (bits == 192) ? 46 : 52;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input string tag, input logic [3:0] idx, input logic inv, input logic [127:0] e);
    exp_t x;
    x.tag = tag;
    x.idx = idx;
    x.inv = inv;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drainScoreboard();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      rk_index = x.idx;
      @(negedge clock);
      if (x.inv) checkOutput(x.tag, obs_inv, x.exp);
      else       checkOutput(x.tag, obs_rk, x.exp);
    end
  endtask

  // Handshake one key, optionally keep key_valid high with another key while busy, then score
  task automatic applyStimulus(input string tag, input int bits, input logic [255:0] k, input int busy_cycles);
    int cycles;
    @(negedge clock);
    sel = bits;
    key_bus = k;
    key_valid_all = 1'b1;
    #1;
    checkOutput({tag, "_ready"}, 128'(obs_ready), 128'd1);
    @(posedge clock);
    #1;
    checkOutput({tag, "_valid_drop"}, 128'(obs_valid), 128'd0);
    if (busy_cycles > 0) key_bus = '0;
    cycles = 0;
    while (obs_valid !== 1'b1 && cycles < 200) begin
      if (cycles >= busy_cycles) key_valid_all = 1'b0;
      @(posedge clock);
      #1;
      cycles++;
      if (busy_cycles > 0 && cycles == busy_cycles)
        checkOutput({tag, "_busy_ready"}, 128'(obs_ready), 128'd0);
    end
    key_valid_all = 1'b0;
    checkOutput({tag, "_latency"}, 128'(cycles), 128'(expected_latency(bits)));
    drainScoreboard();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int widths [3];
    widths = '{128, 192, 256};
    reset = 1'b1;
    key_valid_all = 1'b0;
    key_bus = '0;
    rk_index = '0;
    sel = 128;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    foreach (widths[n]) begin
      sel = widths[n];
      @(negedge clock);
      checkOutput($sformatf("reset_ready_%0d", widths[n]), 128'(obs_ready), 128'd1);
      checkOutput($sformatf("reset_valid_%0d", widths[n]), 128'(obs_valid), 128'd0);
    end

    pushExp("aes128_rk0", 4'd0, 1'b0, K128[255 -: 128]);
    pushExp("aes128_rk1", 4'd1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605);
    pushExp("aes128_rk2", 4'd2, 1'b0, 128'hf2c295f27a96b9435935807a7359f67f);
    pushExp("aes128_rk10", 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    pushExp("aes128_rk11_zero", 4'd11, 1'b0, 128'h0);
    pushExp("aes128_rk15_zero", 4'd15, 1'b0, 128'h0);
`ifdef EXPAND_KEY_INV_MIX_EN
    pushExp("aes128_inv0", 4'd0, 1'b1, K128[255 -: 128]);
    pushExp("aes128_inv1", 4'd1, 1'b1, ref_inv_mix(128'ha0fafe1788542cb123a339392a6c7605));
    pushExp("aes128_inv2", 4'd2, 1'b1, ref_inv_mix(128'hf2c295f27a96b9435935807a7359f67f));
    pushExp("aes128_inv10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    pushExp("aes128_inv11_zero", 4'd11, 1'b1, 128'h0);
`endif
    applyStimulus("aes128", 128, K128, 0);

    pushExp("aes192_rk0", 4'd0, 1'b0, 128'h8e73b0f7da0e6452c810f32b809079e5);
    pushExp("aes192_rk1", 4'd1, 1'b0, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    pushExp("aes192_rk12", 4'd12, 1'b0, 128'he98ba06f448c773c8ecc720401002202);
    pushExp("aes192_rk13_zero", 4'd13, 1'b0, 128'h0);
`ifdef EXPAND_KEY_INV_MIX_EN
    pushExp("aes192_inv0", 4'd0, 1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5);
    pushExp("aes192_inv1", 4'd1, 1'b1, ref_inv_mix(128'h62f8ead2522c6b7bfe0c91f72402f5a5));
    pushExp("aes192_inv12", 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
`endif
    applyStimulus("aes192", 192, K192, 0);

    pushExp("aes256_rk0", 4'd0, 1'b0, 128'h603deb1015ca71be2b73aef0857d7781);
    pushExp("aes256_rk2", 4'd2, 1'b0, 128'h9ba354118e6925afa51a8b5f2067fcde);
    pushExp("aes256_rk3_sub4", 4'd3, 1'b0, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    pushExp("aes256_rk14", 4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e);
    pushExp("aes256_rk15_zero", 4'd15, 1'b0, 128'h0);
`ifdef EXPAND_KEY_INV_MIX_EN
    pushExp("aes256_inv0", 4'd0, 1'b1, 128'h603deb1015ca71be2b73aef0857d7781);
    pushExp("aes256_inv2", 4'd2, 1'b1, ref_inv_mix(128'h9ba354118e6925afa51a8b5f2067fcde));
    pushExp("aes256_inv3", 4'd3, 1'b1, ref_inv_mix(128'ha8b09c1a93d194cdbe49846eb75d5b9a));
    pushExp("aes256_inv14", 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
`endif
    applyStimulus("aes256", 256, K256, 0);

    pushExp("busy_rk1", 4'd1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605);
    pushExp("busy_rk10", 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    applyStimulus("busy", 128, K128, 20);

    pushExp("rekey_rk0", 4'd0, 1'b0, 128'h0);
    pushExp("rekey_rk1", 4'd1, 1'b0, 128'h62636363626363636263636362636363);
    pushExp("rekey_rk2", 4'd2, 1'b0, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    applyStimulus("rekey", 128, 256'h0, 0);

    @(negedge clock);
    sel = 128;
    key_bus = K128;
    key_valid_all = 1'b1;
    @(posedge clock);
    #1;
    key_valid_all = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    checkOutput("rst_mid_busy", 128'(obs_ready), 128'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rst_mid_ready", 128'(obs_ready), 128'd1);
    checkOutput("rst_mid_valid", 128'(obs_valid), 128'd0);
    reset = 1'b0;
    repeat (45) @(posedge clock);
    #1;
    checkOutput("rst_mid_idle_hold", 128'(obs_valid), 128'd0);

    pushExp("post_rst_rk0", 4'd0, 1'b0, K128[255 -: 128]);
    pushExp("post_rst_rk10", 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    applyStimulus("post_rst", 128, K128, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
